pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. It replaces the fixed 16-bit combinational adder wherever a wide add must close timing at the core clock. The operand is split into BLOCK-bit lookahead groups, and each group is registered in its own pipeline stage. A valid/ready handshake with back-pressure carries operands in and results out, and each result comes with carry, signed-overflow and zero flags.

---
 rtl/pipelined_cla_adder_if.sv | 41 ++++
 rtl/pipelined_cla_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// ----------------------------------------------------------------------------
// pipelined_cla_adder_if
//
// Purpose : Operand/result bundle for the pipelined carry-lookahead adder.
//           Carries the input valid/ready handshake with its operands and the
//           output valid/ready handshake with the result and flags.
//
// Signals : in_valid, in_ready  - input handshake
//           a, b, c_in, sub     - operands, carry/borrow in, subtract select
//           out_valid, out_ready- output handshake
//           s, c_out, ovf, zero - result and flags
//
// Modports: master - the producer/consumer around the adder
//           slave  - the adder itself
// ----------------------------------------------------------------------------
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Purpose : Pipelined carry-lookahead adder/subtractor. The operands are split
//           into BLOCK-bit lookahead groups; stage k finalises group k, so the
//           pipeline is NBLK = WIDTH/BLOCK stages deep with NBLK cycles of
//           latency. A single global advance signal moves every stage at once
//           (bubbles included) and holds everything while the output stalls.
//
// Ports   : clk  - rising-edge clock
//           rst  - synchronous, active-high reset
//           bus  - pipelined_cla_adder_if.slave (handshakes, operands, result,
//                  c_out, ovf, zero)
//
// Parameters: WIDTH - operand/result width, multiple of BLOCK
//             BLOCK - lookahead group width (bits finalised per stage)
// ----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NBLK = (BLOCK < 1) ? 1 : WIDTH / BLOCK;

    generate
        if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_param_check
            $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
        end
    endgenerate

    // Stage registers. sum_q[k] holds finalised bits [BLOCK*(k+1)-1:0];
    // a_q/b_q[k] still carry the unprocessed upper groups (b already inverted
    // for subtraction); carry_q[k] is the carry into group k+1.
    logic [NBLK-1:0]  valid_q, valid_d;
    logic [NBLK-1:0]  carry_q, carry_d;
    logic [WIDTH-1:0] sum_q [NBLK];
    logic [WIDTH-1:0] sum_d [NBLK];
    logic [WIDTH-1:0] a_q   [NBLK];
    logic [WIDTH-1:0] a_d   [NBLK];
    logic [WIDTH-1:0] b_q   [NBLK];
    logic [WIDTH-1:0] b_d   [NBLK];
    // Carry into the MSB exists only for the last group, so only one register.
    logic             cmsb_q, cmsb_d;

    // Per-stage sources: stage 0 reads the ports, stage k reads stage k-1.
    logic             src_v   [NBLK];
    logic             src_c   [NBLK];
    logic [WIDTH-1:0] src_a   [NBLK];
    logic [WIDTH-1:0] src_b   [NBLK];
    logic [WIDTH-1:0] src_sum [NBLK];

    logic adv;

    // The whole pipeline moves together; only a stalled output freezes it.
    assign adv          = ~valid_q[NBLK-1] | bus.out_ready;
    assign bus.in_ready = adv & ~rst;

    always_comb begin
        src_v[0]   = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = bus.sub ? ~bus.b : bus.b;
        src_c[0]   = bus.c_in ^ bus.sub;
        src_sum[0] = '0;
        for (int k = 1; k < NBLK; k++) begin
            src_v[k]   = valid_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
    end

    always_comb begin
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        // NOTE: every output of a combinational block gets a value on every
        // path (here a default first) so no latch is inferred.
        cmsb_d = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            g = src_a[k][k*BLOCK +: BLOCK] & src_b[k][k*BLOCK +: BLOCK];
            p = src_a[k][k*BLOCK +: BLOCK] ^ src_b[k][k*BLOCK +: BLOCK];

            // Full lookahead: c[j] = (p[j-1..0] & cin) | OR_m (g[m] & p[j-1..m+1]).
            // Each carry is a flat sum of products, never a chain through c[j-1].
            c[0] = src_c[k];
            for (int j = 1; j <= BLOCK; j++) begin
                term = src_c[k];
                for (int m = 0; m < j; m++) begin
                    term = term & p[m];
                end
                c[j] = term;
                for (int m = 0; m < j; m++) begin
                    term = g[m];
                    for (int n = m + 1; n < j; n++) begin
                        term = term & p[n];
                    end
                    c[j] = c[j] | term;
                end
            end

            valid_d[k]                    = src_v[k];
            sum_d[k]                      = src_sum[k];
            sum_d[k][k*BLOCK +: BLOCK]    = p ^ c[BLOCK-1:0];
            carry_d[k]                    = c[BLOCK];
            a_d[k]                        = src_a[k];
            b_d[k]                        = src_b[k];
            if (k == NBLK - 1) begin
                cmsb_d = c[BLOCK-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every stage is reset, not just the valid bits, because the
            // last stage drives s and the flags, which must read zero after reset.
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            for (int k = 0; k < NBLK; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    assign bus.out_valid = valid_q[NBLK-1];
    assign bus.s         = sum_q[NBLK-1];
    assign bus.c_out     = carry_q[NBLK-1];
    assign bus.ovf       = cmsb_q ^ carry_q[NBLK-1];
    assign bus.zero      = (sum_q[NBLK-1] == '0);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Directed bench for pipelined_cla_adder at three parameter points:
// 16/4 (default), 32/8 and 12/4. All three share clk and rst.
// ----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec16_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();
    pipelined_cla_adder_if #(.WIDTH(12)) bus12 ();

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    pipelined_cla_adder #(.WIDTH(12), .BLOCK(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: wide integer add, overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [63:0] mask;
        logic [63:0] beff;
        logic [63:0] sum;
        res_t        r;
        mask = (64'd1 << w) - 64'd1;
        beff = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        sum  = {32'd0, a} + beff + {63'd0, cin ^ sub};
        r.s  = sum[31:0] & mask[31:0];
        r.c  = sum[w];
        r.v  = (a[w-1] == beff[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    // Present one operand set on the 16-bit DUT and count edges until out_valid.
    task automatic drive16_one(input logic [15:0] op_a, input logic [15:0] op_b,
                               input logic cin, input logic op_sub, output int lat);
        bus16.a = op_a; bus16.b = op_b; bus16.c_in = cin; bus16.sub = op_sub;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic drive32_one(input logic [31:0] op_a, input logic [31:0] op_b,
                               input logic cin, input logic op_sub, output int lat);
        bus32.a = op_a; bus32.b = op_b; bus32.c_in = cin; bus32.sub = op_sub;
        bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic drive12_one(input logic [11:0] op_a, input logic [11:0] op_b,
                               input logic cin, input logic op_sub, output int lat);
        bus12.a = op_a; bus12.b = op_b; bus12.c_in = cin; bus12.sub = op_sub;
        bus12.in_valid = 1'b1; bus12.out_ready = 1'b1;
        @(posedge clk); #1;
        bus12.in_valid = 1'b0;
        lat = 1;
        while (!bus12.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus16.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid); end
        n_cmp++; if (bus16.s !== 16'h0000) begin n_bad++; $display("FAIL reset_s: got %h want 0000", bus16.s); end
        n_cmp++; if (bus16.c_out !== 1'b0) begin n_bad++; $display("FAIL reset_c_out: got %b want 0", bus16.c_out); end
        n_cmp++; if (bus16.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus16.ovf); end
        n_cmp++; if (bus16.zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b want 1", bus16.zero); end
        n_cmp++; if (bus16.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus16.in_ready); end
        n_cmp++; if (bus32.out_valid !== 1'b0 || bus12.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_param_valid: got %b/%b want 0/0", bus32.out_valid, bus12.out_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus16.in_ready); end
    endtask

    task automatic test_single_add();
        int lat;
        drive16_one(16'h1234, 16'h0FCD, 1'b1, 1'b0, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL add_latency: got %0d want 4", lat); end
        n_cmp++; if (bus16.s !== 16'h2202) begin n_bad++; $display("FAIL add_s: got %h want 2202", bus16.s); end
        n_cmp++; if (bus16.c_out !== 1'b0 || bus16.ovf !== 1'b0 || bus16.zero !== 1'b0) begin
            n_bad++; $display("FAIL add_flags: got c=%b v=%b z=%b want 0 0 0", bus16.c_out, bus16.ovf, bus16.zero);
        end
        @(posedge clk); #1;
        n_cmp++; if (bus16.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_one_cycle: got out_valid %b want 0", bus16.out_valid); end
    endtask

    task automatic test_subtract_and_wrap();
        vec16_t vecs [5];
        int     lat;
        //          a        b        cin   sub   s        c     v
        vecs[0] = {16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[1] = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = {16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive16_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want 4", i, lat); end
            n_cmp++; if (bus16.s !== vecs[i].s || bus16.c_out !== vecs[i].c || bus16.ovf !== vecs[i].v ||
                         bus16.zero !== (vecs[i].s == 16'h0000)) begin
                n_bad++;
                $display("FAIL vec%0d_result: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b", i,
                         bus16.s, bus16.c_out, bus16.ovf, bus16.zero,
                         vecs[i].s, vecs[i].c, vecs[i].v, (vecs[i].s == 16'h0000));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        res_t        exp_q [$];
        res_t        e;
        int          sent, got, cyc;
        logic        accepted, prev_stall;
        logic [18:0] snap;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; snap = '0;
        bus16.a = 16'($urandom); bus16.b = 16'($urandom);
        bus16.c_in = 1'($urandom); bus16.sub = 1'($urandom);
        bus16.in_valid = 1'b1;
        while (got < 20 && cyc < 400) begin
            if (prev_stall) begin
                n_cmp++;
                if ({bus16.out_valid, bus16.s, bus16.c_out, bus16.ovf} !== snap) begin
                    n_bad++; $display("FAIL stall_stable: got %h want %h", {bus16.out_valid, bus16.s, bus16.c_out, bus16.ovf}, snap);
                end
            end
            bus16.out_ready = 1'($urandom_range(0, 1));
            if (sent >= 20) bus16.in_valid = 1'b0;
            #1;
            n_cmp++;
            if (bus16.in_ready !== !(bus16.out_valid && !bus16.out_ready)) begin
                n_bad++; $display("FAIL stream_in_ready: got %b want %b", bus16.in_ready, !(bus16.out_valid && !bus16.out_ready));
            end
            if (bus16.out_valid && bus16.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stream_extra: got s=%h want no result", bus16.s);
                end else begin
                    e = exp_q.pop_front();
                    if (bus16.s !== e.s[15:0] || bus16.c_out !== e.c || bus16.ovf !== e.v) begin
                        n_bad++; $display("FAIL stream_result%0d: got s=%h c=%b v=%b want s=%h c=%b v=%b",
                                          got, bus16.s, bus16.c_out, bus16.ovf, e.s[15:0], e.c, e.v);
                    end
                end
                got++;
            end
            accepted = bus16.in_valid && bus16.in_ready;
            if (accepted) begin
                exp_q.push_back(model(16, {16'd0, bus16.a}, {16'd0, bus16.b}, bus16.c_in, bus16.sub));
                sent++;
            end
            prev_stall = bus16.out_valid && !bus16.out_ready;
            snap = {bus16.out_valid, bus16.s, bus16.c_out, bus16.ovf};
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                bus16.a = 16'($urandom); bus16.b = 16'($urandom);
                bus16.c_in = 1'($urandom); bus16.sub = 1'($urandom);
            end
        end
        n_cmp++; if (got !== 20 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL stream_count: got %0d results (%0d pending) want 20 (0)", got, exp_q.size());
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_stream();
        logic seen;
        int   lat;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus16.a = 16'h1111 * 16'(i + 1); bus16.b = 16'h0101;
            bus16.c_in = 1'b0; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus16.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0", bus16.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus16.out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_flushed: got out_valid seen=%b want 0", seen); end
        drive16_one(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL midrst_latency: got %0d want 4", lat); end
        n_cmp++; if (bus16.s !== 16'h1000 || bus16.c_out !== 1'b0) begin
            n_bad++; $display("FAIL midrst_result: got s=%h c=%b want s=1000 c=0", bus16.s, bus16.c_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_param_w32();
        int          lat;
        res_t        e;
        logic [31:0] ra, rb;
        logic        rc, rs;
        drive32_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL w32_latency: got %0d want 4", lat); end
        n_cmp++; if (bus32.s !== 32'h0 || bus32.c_out !== 1'b1 || bus32.zero !== 1'b1 || bus32.ovf !== 1'b0) begin
            n_bad++; $display("FAIL w32_wrap: got s=%h c=%b z=%b v=%b want s=0 c=1 z=1 v=0", bus32.s, bus32.c_out, bus32.zero, bus32.ovf);
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            e = model(32, ra, rb, rc, rs);
            drive32_one(ra, rb, rc, rs, lat);
            n_cmp++; if (lat !== 4 || bus32.s !== e.s || bus32.c_out !== e.c || bus32.ovf !== e.v) begin
                n_bad++; $display("FAIL w32_rand%0d: got lat=%0d s=%h c=%b v=%b want lat=4 s=%h c=%b v=%b",
                                  i, lat, bus32.s, bus32.c_out, bus32.ovf, e.s, e.c, e.v);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_param_w12();
        int          lat;
        res_t        e;
        logic [11:0] ra, rb;
        logic        rc, rs;
        drive12_one(12'hFFF, 12'h001, 1'b0, 1'b0, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL w12_latency: got %0d want 3", lat); end
        n_cmp++; if (bus12.s !== 12'h000 || bus12.c_out !== 1'b1 || bus12.zero !== 1'b1) begin
            n_bad++; $display("FAIL w12_wrap: got s=%h c=%b z=%b want s=000 c=1 z=1", bus12.s, bus12.c_out, bus12.zero);
        end
        drive12_one(12'h7FF, 12'h001, 1'b0, 1'b0, lat);
        n_cmp++; if (bus12.s !== 12'h800 || bus12.ovf !== 1'b1 || bus12.c_out !== 1'b0) begin
            n_bad++; $display("FAIL w12_ovf: got s=%h v=%b c=%b want s=800 v=1 c=0", bus12.s, bus12.ovf, bus12.c_out);
        end
        for (int i = 0; i < 6; i++) begin
            ra = 12'($urandom); rb = 12'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            e = model(12, {20'd0, ra}, {20'd0, rb}, rc, rs);
            drive12_one(ra, rb, rc, rs, lat);
            n_cmp++; if (lat !== 3 || bus12.s !== e.s[11:0] || bus12.c_out !== e.c || bus12.ovf !== e.v) begin
                n_bad++; $display("FAIL w12_rand%0d: got lat=%0d s=%h c=%b v=%b want lat=3 s=%h c=%b v=%b",
                                  i, lat, bus12.s, bus12.c_out, bus12.ovf, e.s[11:0], e.c, e.v);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.c_in = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        bus12.in_valid = 1'b0; bus12.a = '0; bus12.b = '0; bus12.c_in = 1'b0; bus12.sub = 1'b0; bus12.out_ready = 1'b1;

        test_reset();
        test_single_add();
        test_subtract_and_wrap();
        test_back_to_back();
        test_reset_mid_stream();
        test_param_w32();
        test_param_w12();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
